// File: rtl/fp_pack_if.sv
// Handshake bus for fp_pack: operand in (valid/ready), packed result out (valid/ready).
interface fp_pack_if #(
    parameter int NEXP   = 5,
    parameter int NSIG   = 10,
    parameter int NTYPES = 6
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_sign;
    logic signed [NEXP+1:0]   in_exp;
    logic [NSIG+3:0]          in_sig;
    logic [NTYPES-1:0]        in_flags;
    logic                     out_valid;
    logic                     out_ready;
    logic [NEXP+NSIG:0]       out_f;
    logic [3:0]               out_exc;

    modport master (
        output in_valid, in_sign, in_exp, in_sig, in_flags, out_ready,
        input  in_ready, out_valid, out_f, out_exc
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_sig, in_flags, out_ready,
        output in_ready, out_valid, out_f, out_exc
    );
endinterface

// File: rtl/fp_pack.sv
// Float packer: normalizes an extended significand one shift per cycle, rounds to
// nearest-even and assembles an IEEE-754 word with {invalid, overflow, underflow, inexact}.
module fp_pack #(
    parameter int NEXP = 5,
    parameter int NSIG = 10
) (
    input  logic     clk,
    input  logic     reset,
    fp_pack_if.slave io
);
    localparam int SNAN     = 0;
    localparam int QNAN     = 1;
    localparam int INFINITY = 2;
    localparam int ZERO     = 3;
    localparam int EW       = NEXP + 3;
    localparam int SW       = NSIG + 4;
    localparam int BIAS     = (1 << (NEXP - 1)) - 1;

    localparam logic signed [EW-1:0] EMIN_E = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] LIM_E  = EW'(NSIG + 3);
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic signed [EW:0]   BIAS_B = (EW + 1)'(BIAS);
    localparam logic signed [EW:0]   MAXB   = (EW + 1)'((1 << NEXP) - 1);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t                 state, nxtState;
    logic                   sign, nxtSign;
    logic signed [EW-1:0]   exp, nxtExp, shExp, rExp;
    logic [SW-1:0]          sig, nxtSig, shSig;
    logic [NEXP+NSIG:0]     outF, nxtOutF;
    logic [3:0]             outExc, nxtOutExc;
    logic [NSIG+1:0]        m;
    logic signed [EW:0]     biased;
    logic                   up, inexact;
    logic signed [EW-1:0]   inExpExt;

    // True while any normalization step still applies; lets an operand skip NORM
    // entirely, so each NORM cycle is exactly one shift.
    function automatic logic needStep(input logic signed [EW-1:0] e, input logic [SW-1:0] s);
        return s[SW-1] | (e < EMIN_E) | (~s[NSIG+2] & (e > EMIN_E));
    endfunction

    assign inExpExt = {io.in_exp[NEXP+1], io.in_exp};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sign   <= 1'b0;
            exp    <= '0;
            sig    <= '0;
            outF   <= '0;
            outExc <= '0;
        end else begin
            state  <= nxtState;
            sign   <= nxtSign;
            exp    <= nxtExp;
            sig    <= nxtSig;
            outF   <= nxtOutF;
            outExc <= nxtOutExc;
        end
    end

    always_comb begin
        nxtState  = state;
        nxtSign   = sign;
        nxtExp    = exp;
        nxtSig    = sig;
        nxtOutF   = outF;
        nxtOutExc = outExc;
        shExp     = exp;
        shSig     = sig;
        rExp      = exp;
        m         = '0;
        biased    = '0;
        up        = 1'b0;
        inexact   = 1'b0;
        case (state)
            IDLE: begin
                if (io.in_valid) begin
                    nxtSign   = io.in_sign;
                    nxtExp    = inExpExt;
                    nxtSig    = io.in_sig;
                    nxtOutExc = '0;
                    nxtState  = DONE;
                    if (io.in_flags[SNAN]) begin
                        nxtOutF   = {io.in_sign, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
                        nxtOutExc = 4'b1000;
                    end else if (io.in_flags[QNAN]) begin
                        nxtOutF = {io.in_sign, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
                    end else if (io.in_flags[INFINITY]) begin
                        nxtOutF = {io.in_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
                    end else if (io.in_flags[ZERO] || io.in_sig == '0) begin
                        nxtOutF = {io.in_sign, {(NEXP+NSIG){1'b0}}};
                    end else begin
                        nxtState = needStep(inExpExt, io.in_sig) ? NORM : ROUND;
                    end
                end
            end
            NORM: begin
                if (sig[SW-1]) begin
                    shSig = {1'b0, sig[SW-1:2], sig[1] | sig[0]};
                    shExp = exp + ONE_E;
                end else if (exp < EMIN_E) begin
                    // Far below the subnormal range only the sticky survives.
                    if ((EMIN_E - exp) > LIM_E) begin
                        shSig = {{(SW-1){1'b0}}, |sig};
                        shExp = EMIN_E;
                    end else begin
                        shSig = {1'b0, sig[SW-1:2], sig[1] | sig[0]};
                        shExp = exp + ONE_E;
                    end
                end else if (!sig[NSIG+2] && exp > EMIN_E) begin
                    shSig = {sig[SW-2:0], 1'b0};
                    shExp = exp - ONE_E;
                end
                nxtSig   = shSig;
                nxtExp   = shExp;
                nxtState = needStep(shExp, shSig) ? NORM : ROUND;
            end
            ROUND: begin
                up = sig[1] & (sig[0] | sig[2]);
                m  = {1'b0, sig[NSIG+2:2]} + (NSIG+2)'(up);
                if (m[NSIG+1]) begin
                    m    = m >> 1;
                    rExp = exp + ONE_E;
                end
                // A subnormal rounding into the hidden bit lands on biased 1 since exp==EMIN.
                biased  = m[NSIG] ? ({rExp[EW-1], rExp} + BIAS_B) : '0;
                inexact = sig[1] | sig[0];
                if (biased >= MAXB) begin
                    nxtOutF   = {sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
                    nxtOutExc = 4'b0101;
                end else begin
                    nxtOutF   = {sign, biased[NEXP-1:0], m[NSIG-1:0]};
                    nxtOutExc = {2'b00, ~sig[NSIG+2] & inexact, inexact};
                end
                nxtState = DONE;
            end
            DONE: begin
                if (io.out_ready) nxtState = IDLE;
            end
            default: nxtState = IDLE;
        endcase
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.out_f     = outF;
    assign io.out_exc   = outExc;
endmodule

// File: tb/tb_fp_pack.sv
// Bench for fp_pack (binary16): directed corner cases plus random operands scored
// against an exact-value round-to-nearest-even model.
module tb_fp_pack;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_pack_if #(.NEXP(5), .NSIG(10), .NTYPES(6)) bus ();
    fp_pack #(.NEXP(5), .NSIG(10)) dut (.clk(clk), .reset(reset), .io(bus));

    localparam logic [5:0] F_SNAN = 6'b000001;
    localparam logic [5:0] F_QNAN = 6'b000010;
    localparam logic [5:0] F_INF  = 6'b000100;
    localparam logic [5:0] F_ZERO = 6'b001000;
    localparam logic [5:0] F_SUB  = 6'b010000;
    localparam logic [5:0] F_NORM = 6'b100000;

    int checks = 0;
    int failures = 0;
    logic [15:0] gotF;
    logic [3:0]  gotX;
    int          gotLat;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Exact value sg * 2^(e-12), rounded to nearest-even at the binary16 quantum.
    function automatic void refModel(input logic s, input int e, input logic [13:0] sg,
                                     input logic [5:0] fl, output logic [15:0] f, output logic [3:0] x);
        int msb, ulp, sh, k, biased;
        longint n, rem, half;
        logic inexact, tiny;
        f = '0; x = '0; msb = 0; n = 0; inexact = 1'b0;
        if (fl[0]) begin
            f = {s, 15'h7E00}; x = 4'b1000;
        end else if (fl[1]) begin
            f = {s, 15'h7E00};
        end else if (fl[2]) begin
            f = {s, 15'h7C00};
        end else if (fl[3] || sg == 0) begin
            f = {s, 15'h0000};
        end else begin
            for (int i = 0; i < 14; i++) if (sg[i]) msb = i;
            tiny = (msb + e - 12) < -14;
            ulp = msb + e - 22;
            if (ulp < -24) ulp = -24;
            sh = e - 12 - ulp;
            if (sh >= 0) begin
                n = longint'(sg) << sh;
            end else begin
                k = -sh;
                if (k > 20) begin
                    n = 0; inexact = 1'b1;
                end else begin
                    n    = longint'(sg) >> k;
                    rem  = longint'(sg) & ((longint'(1) << k) - 1);
                    half = longint'(1) << (k - 1);
                    inexact = (rem != 0);
                    if (rem > half || (rem == half && n[0])) n++;
                end
            end
            if (n == 2048) begin n = 1024; ulp++; end
            biased = ulp + 25;
            if (n >= 1024 && biased >= 31) begin
                f = {s, 15'h7C00}; x = 4'b0101;
            end else begin
                f = {s, (n >= 1024) ? 5'(biased) : 5'd0, n[9:0]};
                x = {2'b00, tiny & inexact, inexact};
            end
        end
    endfunction

    task automatic runOp(input logic s, input int e, input logic [13:0] sg, input logic [5:0] fl);
        @(negedge clk);
        bus.in_sign  = s;
        bus.in_exp   = e[6:0];
        bus.in_sig   = sg;
        bus.in_flags = fl;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        gotLat = 1;
        while (!bus.out_valid && gotLat < 64) begin
            @(posedge clk); #1;
            gotLat++;
        end
        gotF = bus.out_f;
        gotX = bus.out_exc;
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".drop"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic dirOp(input string tag, input logic s, input int e, input logic [13:0] sg,
                         input logic [5:0] fl, input logic [15:0] ef, input logic [3:0] ex, input int el);
        runOp(s, e, sg, fl);
        chk({tag, ".f"}, {16'd0, gotF}, {16'd0, ef});
        chk({tag, ".exc"}, {28'd0, gotX}, {28'd0, ex});
        chk({tag, ".lat"}, gotLat, el);
        drain(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0;
        bus.in_sig = '0; bus.in_flags = '0; bus.out_ready = 1'b1;
        #2;
        chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst.in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst.out_f",     {16'd0, bus.out_f},     32'd0);
        chk("rst.out_exc",   {28'd0, bus.out_exc},   32'd0);
        @(negedge clk); reset = 1'b0;

        dirOp("one",      1'b0,   0, 14'h1000, F_NORM, 16'h3C00, 4'b0000, 2);
        dirOp("lnorm",    1'b0,   3, 14'h0400, F_NORM, 16'h4000, 4'b0000, 4);
        dirOp("rcarry",   1'b0,   0, 14'h1FFE, F_NORM, 16'h4000, 4'b0001, 2);
        dirOp("tieeven",  1'b0,   0, 14'h1002, F_NORM, 16'h3C00, 4'b0001, 2);
        dirOp("ovf",      1'b0,  15, 14'h2000, F_NORM, 16'h7C00, 4'b0101, 3);
        dirOp("ovfneg",   1'b1,  15, 14'h2000, F_NORM, 16'hFC00, 4'b0101, 3);
        dirOp("maxnorm",  1'b0,  15, 14'h1FFC, F_NORM, 16'h7BFF, 4'b0000, 2);
        dirOp("ovfround", 1'b0,  15, 14'h1FFE, F_NORM, 16'h7C00, 4'b0101, 2);
        dirOp("subn",     1'b1, -15, 14'h1000, F_SUB,  16'h8200, 4'b0000, 3);
        dirOp("collapse", 1'b1, -40, 14'h1001, F_NORM, 16'h8000, 4'b0011, 3);
        dirOp("minsub",   1'b0, -24, 14'h1000, F_NORM, 16'h0001, 4'b0000, 12);
        dirOp("sub2norm", 1'b0, -15, 14'h1FFF, F_NORM, 16'h0400, 4'b0011, 3);
        dirOp("qnan",     1'b1,   0, 14'h1000, F_QNAN, 16'hFE00, 4'b0000, 1);
        dirOp("inf",      1'b0,   0, 14'h1000, F_INF,  16'h7C00, 4'b0000, 1);
        dirOp("zero",     1'b1,   5, 14'h1234, F_ZERO, 16'h8000, 4'b0000, 1);
        dirOp("sigzero",  1'b0,   5, 14'h0000, F_NORM, 16'h0000, 4'b0000, 1);
        dirOp("prio",     1'b0,   0, 14'h1000, F_SNAN | F_INF | F_ZERO, 16'h7E00, 4'b1000, 1);

        // Result must hold while the consumer stalls.
        bus.out_ready = 1'b0;
        runOp(1'b0, 0, 14'h1000, F_SNAN);
        chk("hold.f",   {16'd0, gotF}, 32'h7E00);
        chk("hold.exc", {28'd0, gotX}, 32'h8);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("hold.valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold.stable", {16'd0, bus.out_f}, 32'h7E00);
        end
        drain("hold");

        // Reset while shifting discards the operand.
        @(negedge clk);
        bus.in_sign = 1'b0; bus.in_exp = 7'd20; bus.in_sig = 14'h0001;
        bus.in_flags = F_NORM; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst.in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(negedge clk); reset = 1'b0;
        dirOp("afterrst", 1'b0, 0, 14'h1000, F_NORM, 16'h3C00, 4'b0000, 2);

        for (int i = 0; i < 300; i++) begin
            logic s;
            int e;
            logic [13:0] sg;
            logic [5:0] fl;
            logic [15:0] ef;
            logic [3:0] ex;
            s  = 1'($urandom_range(0, 1));
            e  = int'($urandom_range(0, 80)) - 45;
            sg = 14'($urandom) >> $urandom_range(0, 13);
            case ($urandom_range(0, 9))
                0: fl = 6'($urandom);
                1: fl = F_SUB;
                default: fl = F_NORM;
            endcase
            refModel(s, e, sg, fl, ef, ex);
            runOp(s, e, sg, fl);
            chk("rnd.valid", {31'd0, bus.out_valid}, 32'd1);
            chk("rnd.f",   {16'd0, gotF}, {16'd0, ef});
            chk("rnd.exc", {28'd0, gotX}, {28'd0, ex});
            drain("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
